// File: rtl/db_arbiter.sv
// Data-break arbiter: grants one of NREQ requesters a CPU data-break cycle; DB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency: req to data_break 2 cycles, DB1 state to ack 1 cycle; WAIT aborts after TMO cycles without DB1.
// Backpressure: requests are level-held until ack; losers simply stay pending, nothing is dropped.
module db_arbiter #(
  parameter int          NREQ     = 4,
  parameter logic [4:0]  DB1_CODE = 5'd10,
  parameter int          TMO      = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*15-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*12-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [11:0]          rdata,
  output logic [NREQ-1:0]      tmo_err,
  input  logic [4:0]           state,
  output logic                 data_break,
  output logic                 to_disk,
  output logic [14:0]          dmaAddr,
  output logic [11:0]          dmaDOUT,
  input  logic [11:0]          dmaDIN
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      fsm;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   win_nxt;
  logic [CW-1:0]   tmo_cnt;
  logic [NREQ-1:0] req_q;

`ifdef DB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // Scan downward so the candidate closest to rr_ptr is assigned last and wins.
  always_comb begin
    win_nxt = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) win_nxt = IW'((int'(rr_ptr) + k) % NREQ);
    end
  end
`else
  always_comb begin
    win_nxt = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) win_nxt = IW'(k);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm        <= S_IDLE;
      win_q      <= '0;
      tmo_cnt    <= '0;
      req_q      <= '0;
      ack        <= '0;
      rdata      <= '0;
      tmo_err    <= '0;
      data_break <= 1'b0;
      to_disk    <= 1'b0;
      dmaAddr    <= '0;
      dmaDOUT    <= '0;
`ifdef DB_ROUND_ROBIN_EN
      rr_ptr     <= '0;
`endif
    end else begin
      ack     <= '0;
      req_q   <= req;
      // Falling req clears the flag; a timeout set later in this block takes precedence.
      tmo_err <= tmo_err & ~(req_q & ~req);
      case (fsm)
        S_IDLE: begin
          if (|req) begin
            win_q   <= win_nxt;
            dmaAddr <= req_addr[int'(win_nxt) * 15 +: 15];
            to_disk <= req_wr[win_nxt];
            dmaDOUT <= req_wdata[int'(win_nxt) * 12 +: 12];
            fsm     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          data_break <= 1'b1;
          tmo_cnt    <= '0;
          fsm        <= S_WAIT;
        end
        S_WAIT: begin
          if (state == DB1_CODE) begin
            data_break <= 1'b0;
            fsm        <= S_DONE;
          end else if (tmo_cnt >= CW'(TMO - 1)) begin
            data_break     <= 1'b0;
            tmo_err[win_q] <= 1'b1;
            fsm            <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_DONE: begin
          rdata      <= dmaDIN;
          ack[win_q] <= 1'b1;
`ifdef DB_ROUND_ROBIN_EN
          rr_ptr     <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
`endif
          fsm        <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db_arbiter.sv
// Directed bench for db_arbiter: single transfers, read data, timeout, async reset and arbitration order.
module tb_db_arbiter;

  localparam logic [4:0] DB1 = 5'd10;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [59:0] req_addr;
  logic [3:0]  req_wr;
  logic [47:0] req_wdata;
  logic [3:0]  ack;
  logic [11:0] rdata;
  logic [3:0]  tmo_err;
  logic [4:0]  state;
  logic        data_break;
  logic        to_disk;
  logic [14:0] dmaAddr;
  logic [11:0] dmaDOUT;
  logic [11:0] dmaDIN;

  int n_chk  = 0;
  int n_fail = 0;

  db_arbiter #(.NREQ(4), .DB1_CODE(DB1), .TMO(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .req_wr     (req_wr),
    .req_wdata  (req_wdata),
    .ack        (ack),
    .rdata      (rdata),
    .tmo_err    (tmo_err),
    .state      (state),
    .data_break (data_break),
    .to_disk    (to_disk),
    .dmaAddr    (dmaAddr),
    .dmaDOUT    (dmaDOUT),
    .dmaDIN     (dmaDIN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Acts as the CPU: answers data_break with DB1 on the next edge; bounded by budget cycles.
  task automatic wait_ack(input int budget, output logic [3:0] got);
    got = 4'b0000;
    for (int i = 0; i < budget; i++) begin
      state = data_break ? DB1 : 5'd0;
      tick();
      if (ack != 4'b0000) begin
        got = ack;
        break;
      end
    end
    state = 5'd0;
  endtask

  initial begin
    logic [3:0] got;
    int         n_grants;
    bit         rr_mode;
`ifdef DB_ROUND_ROBIN_EN
    n_grants = 5;
    rr_mode  = 1'b1;
`else
    n_grants = 4;
    rr_mode  = 1'b0;
`endif
    reset = 1'b0; req = '0; req_addr = '0; req_wr = '0; req_wdata = '0;
    state = 5'd0; dmaDIN = '0;
    tick(); tick();
    chk("rst_data_break", 32'(data_break), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dmaAddr", 32'(dmaAddr), 0);
    chk("rst_dmaDOUT", 32'(dmaDOUT), 0);
    chk("rst_to_disk", 32'(to_disk), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_tmo_err", 32'(tmo_err), 0);
    reset = 1'b1;
    tick();

    // Write transfer from requester 0, DB1 three cycles after data_break.
    req_addr[0 +: 15] = 15'o01234; req_wr[0] = 1'b1; req_wdata[0 +: 12] = 12'o7070;
    req = 4'b0001;
    tick();
    chk("wr_db_after1", 32'(data_break), 0);
    tick();
    chk("wr_db_after2", 32'(data_break), 1);
    chk("wr_dmaAddr", 32'(dmaAddr), 'o01234);
    chk("wr_dmaDOUT", 32'(dmaDOUT), 'o7070);
    chk("wr_to_disk", 32'(to_disk), 1);
    tick(); tick();
    chk("wr_db_held", 32'(data_break), 1);
    state = DB1;
    tick();
    state = 5'd0;
    chk("wr_db_drop", 32'(data_break), 0);
    chk("wr_no_early_ack", 32'(ack), 0);
    chk("wr_addr_stable", 32'(dmaAddr), 'o01234);
    tick();
    req = 4'b0000;
    chk("wr_ack", 32'(ack), 'b0001);
    tick();
    chk("wr_ack_pulse", 32'(ack), 0);

    // Read transfer from requester 1.
    req_addr[15 +: 15] = 15'o20000; req_wr[1] = 1'b0;
    req = 4'b0010;
    tick(); tick();
    chk("rd_db", 32'(data_break), 1);
    chk("rd_to_disk", 32'(to_disk), 0);
    chk("rd_dmaAddr", 32'(dmaAddr), 'o20000);
    state = DB1; dmaDIN = 12'o5252;
    tick();
    state = 5'd0;
    tick();
    req = 4'b0000;
    chk("rd_ack", 32'(ack), 'b0010);
    chk("rd_rdata", 32'(rdata), 'o5252);
    tick();

    // Timeout: requester 2, no DB1; TMO=8 WAIT cycles.
    req_addr[30 +: 15] = 15'o00100;
    req = 4'b0100;
    tick(); tick();
    chk("tmo_db_start", 32'(data_break), 1);
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_db_before", 32'(data_break), 1);
    tick();
    chk("tmo_db_drop", 32'(data_break), 0);
    chk("tmo_err_set", 32'(tmo_err), 'b0100);
    chk("tmo_no_ack", 32'(ack), 0);
    req = 4'b0000;
    tick();
    chk("tmo_err_clear", 32'(tmo_err), 0);
    chk("tmo_no_ack2", 32'(ack), 0);
    tick();

    // Asynchronous reset during WAIT.
    req_addr[0 +: 15] = 15'o00777; req_wr[0] = 1'b1; req_wdata[0 +: 12] = 12'o1111;
    req = 4'b0001;
    tick(); tick(); tick();
    chk("arst_in_wait", 32'(data_break), 1);
    reset = 1'b0;
    #1;
    chk("arst_db", 32'(data_break), 0);
    chk("arst_dmaAddr", 32'(dmaAddr), 0);
    chk("arst_dmaDOUT", 32'(dmaDOUT), 0);
    chk("arst_to_disk", 32'(to_disk), 0);
    chk("arst_rdata", 32'(rdata), 0);
    req = 4'b0000;
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("arst_no_ack", 32'(ack), 0);
    req_addr[15 +: 15] = 15'o12345; req_wr[1] = 1'b0;
    req = 4'b0010;
    wait_ack(20, got);
    req = 4'b0000;
    chk("post_rst_ack", 32'(got), 'b0010);
    chk("post_rst_addr", 32'(dmaAddr), 'o12345);
    tick();

    // Arbitration order with all requests held, from a clean reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    req = 4'b1111;
    for (int g = 0; g < n_grants; g++) begin
      wait_ack(20, got);
      if (g == n_grants - 1) req = 4'b0000;
      chk($sformatf("grant_%0d", g), 32'(got),
          rr_mode ? 32'(4'b0001 << (g % 4)) : 32'(4'b0001));
    end
    tick(); tick();
    chk("final_idle_db", 32'(data_break), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/db_arbiter.md
DB_ARBITER -- requirements
Module: db_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of data-break requesters, range 2..4.
REQ-002 Parameter DB1_CODE, default 5'd? (the codebase DB1 state code): CPU state value marking the data-break transfer cycle.
REQ-003 Parameter TMO, default 1023: cycles to wait for the CPU to service a granted break before aborting it.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester break request; level held until its ack.
REQ-007 req_addr  in  NREQ*15  per-requester 15-bit memory address.
REQ-008 req_wr  in  NREQ  per-requester direction; 1 = device to memory.
REQ-009 req_wdata  in  NREQ*12  per-requester write data.
REQ-010 ack  out  NREQ  one-cycle pulse: the transfer for that requester completed.
REQ-011 rdata  out  12  memory read data; valid in the ack cycle.
REQ-012 tmo_err  out  NREQ  sticky per-requester timeout flag.
REQ-013 state  in  5  CPU major state.
REQ-014 data_break  out  1  break request to the CPU.
REQ-015 to_disk  out  1  break direction to the CPU; 1 = write to memory.
REQ-016 dmaAddr  out  15  break address.
REQ-017 dmaDOUT  out  12  data to memory.
REQ-018 dmaDIN  in  12  data from memory.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-020 In IDLE with any req bit set, the block SHALL select one winner, latch its addr/wr/wdata into dmaAddr/to_disk/dmaDOUT and go to ISSUE next cycle.
REQ-021 In ISSUE the block SHALL assert data_break, clear the timeout counter and go to WAIT.
REQ-022 In WAIT the block SHALL hold data_break high until state == DB1_CODE, then deassert it and go to DONE.
REQ-023 In DONE the block SHALL sample dmaDIN into rdata, pulse ack[winner] for exactly one cycle and return to IDLE.
REQ-024 Latency from winning req to data_break high SHALL be 2 cycles; DB1 to ack SHALL be 1 cycle.
REQ-025 dmaAddr, to_disk and dmaDOUT SHALL stay constant from ISSUE through DONE.
REQ-026 Requesters that deassert req before ack SHALL be ignored at the next arbitration; a winner dropping req mid-transfer SHALL still complete the break.
REQ-027 If WAIT lasts TMO cycles without DB1, the block SHALL drop data_break, set tmo_err[winner], issue no ack, and return to IDLE.
REQ-028 The timeout counter SHALL saturate, never wrap.
REQ-029 tmo_err[i] SHALL clear when req[i] falls.
REQ-030 A req arriving in the same cycle as another requester's ack SHALL be eligible at the next IDLE arbitration.
REQ-031 Only one requester SHALL ever be granted; ack SHALL be one-hot or zero.

Reset
REQ-032 On reset low the block SHALL go to IDLE at once, without waiting for clk.
REQ-033 Reset SHALL clear data_break, to_disk, dmaAddr, dmaDOUT, rdata, ack, tmo_err and the round-robin pointer to 0.
REQ-034 A reset during WAIT SHALL abandon the break with no ack.

Configuration
REQ-035 With macro DB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin.
REQ-036 In round-robin mode the search SHALL start at the index after the last ack'd winner and wrap modulo NREQ.
REQ-037 Without DB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, lowest index first, and the pointer logic SHALL be absent.

Verification
REQ-038 Scenario: req[0] with addr 15'o01234, wr=1, wdata 12'o7070; DB1 three cycles after data_break -> data_break high 2 cycles after req, dmaAddr=01234, dmaDOUT=7070, to_disk=1, ack[0] pulse one cycle after DB1.
REQ-039 Scenario: req[1] read of 15'o20000 with dmaDIN=12'o5252 at DB1 -> rdata=5252 and ack[1] in the same cycle.
REQ-040 Scenario: req=4'b1111 held, no macro -> four grants, all to requester 0; with DB_ROUND_ROBIN_EN -> grant order 0,1,2,3,0.
REQ-041 Scenario: TMO=8, no DB1 -> data_break drops after 8 WAIT cycles, tmo_err[winner]=1, no ack; tmo_err clears when req falls.
REQ-042 Scenario: reset asserted mid-WAIT -> data_break=0 immediately (asynchronous); all outputs zero; next req served normally.
